// File: rtl/nanorv32_prefetch_pkg.sv
// Shared constants and types for the nanorv32 front end.
package nanorv32_prefetch_pkg;

    // Pipeline-state constants used by the flow controller.
    localparam logic [1:0] NANORV32_PIPE_IDLE  = 2'd0;
    localparam logic [1:0] NANORV32_PIPE_RUN   = 2'd1;
    localparam logic [1:0] NANORV32_PIPE_STALL = 2'd2;
    localparam logic [1:0] NANORV32_PIPE_FLUSH = 2'd3;

    // Fetch-stage constants.
    localparam int unsigned NANORV32_INST_WIDTH        = 32;
    localparam logic [31:0] NANORV32_RESET_ADDR        = 32'h0000_0000;
    localparam int unsigned NANORV32_FETCH_ENTRY_WIDTH = 2 * NANORV32_INST_WIDTH;
    localparam logic [31:0] NANORV32_PC_STEP           = 32'd4;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [31:0]                    pc;
        logic [NANORV32_INST_WIDTH-1:0] word;
    } fetch_entry_t;

    // Clear the byte-offset bits of an instruction address.
    function automatic logic [31:0] align_word_addr(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/nanorv32_fetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, word} entries.
module nanorv32_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    // DEPTH is a power of two, so pointers wrap by overflow.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    assign do_push_c = push && !full;
    assign do_pop_c  = pop && !empty;

    // Next-state: flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push_c && !do_pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop_c && !do_push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State register; reset also clears storage so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nanorv32_prefetch.sv
// Instruction prefetch: owns the fetch PC, drives code memory, buffers words for decode.
module nanorv32_prefetch
    import nanorv32_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = NANORV32_RESET_ADDR,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_redirect,
    input  logic [31:0] branch_target,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        cpu_codeif_req,
    output logic [31:0] cpu_codeif_addr,
    input  logic        codeif_cpu_ready,
    input  logic [31:0] codeif_cpu_rdata,
    output logic        codeif_cpu_ready_r
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         started_q, started_d;
    logic         cpu_ready_r_q, cpu_ready_r_d;
    logic         fifo_full;
    logic         fifo_empty;
    logic         xfer_c;
    logic         pop_c;
    fetch_entry_t push_entry_c;
    fetch_entry_t head_entry;

    // Request is dropped in a redirect cycle so no stale word can complete.
    assign cpu_codeif_req  = started_q && !fifo_full && !branch_redirect;
    assign cpu_codeif_addr = fetch_pc_q;
    assign xfer_c          = cpu_codeif_req && codeif_cpu_ready;

    assign inst_valid         = !fifo_empty;
    assign pop_c              = inst_valid && inst_ready;
    assign inst               = head_entry.word;
    assign inst_pc            = head_entry.pc;
    assign codeif_cpu_ready_r = cpu_ready_r_q;

    // Next fetch PC and handshake flag; redirect has top priority.
    always_comb begin
        fetch_pc_d        = fetch_pc_q;
        started_d         = 1'b1;
        cpu_ready_r_d     = xfer_c;
        push_entry_c.pc   = fetch_pc_q;
        push_entry_c.word = codeif_cpu_rdata;
        if (branch_redirect) begin
            fetch_pc_d = align_word_addr(branch_target);
        end else if (xfer_c) begin
            fetch_pc_d = fetch_pc_q + NANORV32_PC_STEP;
        end
    end

    // Fetch-state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_ADDR;
            started_q     <= 1'b0;
            cpu_ready_r_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            started_q     <= started_d;
            cpu_ready_r_q <= cpu_ready_r_d;
        end
    end

    nanorv32_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NANORV32_FETCH_ENTRY_WIDTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (xfer_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .flush     (branch_redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_entry)
    );

endmodule

// File: tb/tb_nanorv32_prefetch.sv
// Randomised and directed bench for nanorv32_prefetch against a queue-based model.
module tb_nanorv32_prefetch;

    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
    localparam logic [31:0] RA_M   = 32'h0000_0000;
    localparam int          DEPTH_M = 2;
    localparam logic [31:0] RA_W   = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    logic        clk;
    // main instance (defaults)
    logic        rst_n, branch_redirect, inst_ready, inst_valid;
    logic        cpu_codeif_req, codeif_cpu_ready, codeif_cpu_ready_r;
    logic [31:0] branch_target, inst, inst_pc, cpu_codeif_addr, codeif_cpu_rdata;
    // wrap instance (RESET_ADDR near top, DEPTH 4)
    logic        rst_n_w, redirect_w, inst_ready_w, inst_valid_w;
    logic        req_w, mrdy_w, rdy_r_w;
    logic [31:0] target_w, inst_w, inst_pc_w, addr_w, rdata_w;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_started, m_rdyr, m_fresh;

    // last observed outputs of the main instance
    logic        o_valid, o_req, o_rdyr;
    logic [31:0] o_pc, o_inst, o_addr;

    nanorv32_prefetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch_redirect    (branch_redirect),
        .branch_target      (branch_target),
        .inst_ready         (inst_ready),
        .inst               (inst),
        .inst_pc            (inst_pc),
        .inst_valid         (inst_valid),
        .cpu_codeif_req     (cpu_codeif_req),
        .cpu_codeif_addr    (cpu_codeif_addr),
        .codeif_cpu_ready   (codeif_cpu_ready),
        .codeif_cpu_rdata   (codeif_cpu_rdata),
        .codeif_cpu_ready_r (codeif_cpu_ready_r)
    );

    nanorv32_prefetch #(
        .RESET_ADDR (RA_W),
        .DEPTH      (4)
    ) dut_w (
        .clk                (clk),
        .rst_n              (rst_n_w),
        .branch_redirect    (redirect_w),
        .branch_target      (target_w),
        .inst_ready         (inst_ready_w),
        .inst               (inst_w),
        .inst_pc            (inst_pc_w),
        .inst_valid         (inst_valid_w),
        .cpu_codeif_req     (req_w),
        .cpu_codeif_addr    (addr_w),
        .codeif_cpu_ready   (mrdy_w),
        .codeif_cpu_rdata   (rdata_w),
        .codeif_cpu_ready_r (rdy_r_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RA_M;
        m_started = 1'b0;
        m_rdyr    = 1'b0;
        m_fresh   = 1'b1;
    endtask

    // One clock of the main instance: drive, compare against model, advance model.
    task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt,
                         input logic ird, input logic mrdy, input logic use_key);
        logic        e_valid, e_req, xfer;
        logic [31:0] data;
        ent_t        e;
        @(negedge clk);
        data             = use_key ? (m_pc ^ KEY) : $urandom;
        rst_n            = rst;
        branch_redirect  = redir;
        branch_target    = tgt;
        inst_ready       = ird;
        codeif_cpu_ready = mrdy;
        codeif_cpu_rdata = data;
        #1;
        e_valid = (mq.size() != 0);
        e_req   = m_started && (mq.size() < DEPTH_M) && !redir;
        check_eq("valid", 32'(inst_valid), 32'(e_valid));
        check_eq("req", 32'(cpu_codeif_req), 32'(e_req));
        check_eq("addr", cpu_codeif_addr, m_pc);
        check_eq("ready_r", 32'(codeif_cpu_ready_r), 32'(m_rdyr));
        if (e_valid) begin
            check_eq("inst_pc", inst_pc, mq[0].pc);
            check_eq("inst", inst, mq[0].w);
        end else if (m_fresh) begin
            check_eq("inst_pc_zero", inst_pc, 32'h0);
            check_eq("inst_zero", inst, 32'h0);
        end
        o_valid = inst_valid;
        o_req   = cpu_codeif_req;
        o_rdyr  = codeif_cpu_ready_r;
        o_pc    = inst_pc;
        o_inst  = inst;
        o_addr  = cpu_codeif_addr;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (redir) begin
            mq.delete();
            m_pc      = tgt & 32'hFFFF_FFFC;
            m_rdyr    = 1'b0;
            m_started = 1'b1;
        end else begin
            xfer = e_req && mrdy;
            if (e_valid && ird) void'(mq.pop_front());
            if (xfer) begin
                e.pc = m_pc;
                e.w  = data;
                mq.push_back(e);
                m_pc    = m_pc + 32'd4;
                m_fresh = 1'b0;
            end
            m_rdyr    = xfer;
            m_started = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        r_rst, r_redir, r_ird, r_mrdy, r_key;
        logic [31:0] r_tgt;

        rst_n = 1'b0; branch_redirect = 1'b0; branch_target = '0;
        inst_ready = 1'b0; codeif_cpu_ready = 1'b0; codeif_cpu_rdata = '0;
        rst_n_w = 1'b0; redirect_w = 1'b0; target_w = '0;
        inst_ready_w = 1'b1; mrdy_w = 1'b0; rdata_w = '0;
        @(posedge clk);
        model_reset();

        // Reset held low for three edges, then released.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            check_eq("rst_req", 32'(o_req), 32'h0);
            check_eq("rst_valid", 32'(o_valid), 32'h0);
            check_eq("rst_inst", o_inst, 32'h0);
            check_eq("rst_inst_pc", o_pc, 32'h0);
            check_eq("rst_addr", o_addr, RA_M);
            check_eq("rst_ready_r", 32'(o_rdyr), 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("rel0_req", 32'(o_req), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("rel1_req", 32'(o_req), 32'h1);
        check_eq("rel1_addr", o_addr, RA_M);

        // Streaming with a zero-wait memory.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (i == 0) begin
                check_eq("str_req0", 32'(o_req), 32'h1);
                check_eq("str_addr0", o_addr, 32'h0);
            end else begin
                check_eq("str_valid", 32'(o_valid), 32'h1);
                check_eq("str_pc", o_pc, 32'(4 * (i - 1)));
                check_eq("str_inst", o_inst, 32'(4 * (i - 1)) ^ KEY);
            end
        end

        // Backpressure: redirect to 0 for a clean start, then hold inst_ready low.
        cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_redir_req", 32'(o_req), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_c2_valid", 32'(o_valid), 32'h0);
        check_eq("bp_c2_addr", o_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_c3_addr", o_addr, 32'h4);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_full_req", 32'(o_req), 32'h0);
        check_eq("bp_full_pc", o_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("bp_pop0_req", 32'(o_req), 32'h0);
        check_eq("bp_pop0_pc", o_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_resume_pc", o_pc, 32'h4);
        check_eq("bp_resume_req", 32'(o_req), 32'h1);
        check_eq("bp_resume_addr", o_addr, 32'h8);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_eq("bp_refull_req", 32'(o_req), 32'h0);

        // Redirect while full and memory ready.
        cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b1);
        check_eq("rd_cycle_req", 32'(o_req), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("rd_valid", 32'(o_valid), 32'h0);
        check_eq("rd_req", 32'(o_req), 32'h1);
        check_eq("rd_addr", o_addr, 32'h0000_0100);
        check_eq("rd_ready_r", 32'(o_rdyr), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("rd_tgt_pc", o_pc, 32'h0000_0100);
        check_eq("rd_tgt_inst", o_inst, 32'h0000_0100 ^ KEY);

        // Reset mid-stream with one entry buffered and a live request.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("mr_pre_req", 32'(o_req), 32'h1);
        check_eq("mr_pre_valid", 32'(o_valid), 32'h1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("mr_valid", 32'(o_valid), 32'h0);
        check_eq("mr_req", 32'(o_req), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_eq("mr_restart_addr", o_addr, RA_M);
        check_eq("mr_restart_req", 32'(o_req), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            r_rst   = ($urandom_range(0, 63) != 0);
            r_redir = ($urandom_range(0, 7) == 0);
            r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            r_ird   = 1'($urandom_range(0, 1));
            r_mrdy  = ($urandom_range(0, 4) < 3);
            r_key   = 1'($urandom_range(0, 1));
            cycle(r_rst, r_redir, r_tgt, r_ird, r_mrdy, r_key);
        end

        // Wrap instance: two wait states per access, address wraps past the top.
        @(negedge clk);
        rst_n_w = 1'b1;
        #1;
        check_eq("w_rel_req", 32'(req_w), 32'h0);
        check_eq("w_rel_addr", addr_w, RA_W);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_addr = RA_W + 32'(4 * (k / 3));
            mrdy_w   = (k % 3 == 2);
            rdata_w  = exp_addr ^ KEY;
            #1;
            check_eq("w_req", 32'(req_w), 32'h1);
            check_eq("w_addr", addr_w, exp_addr);
            check_eq("w_ready_r", 32'(rdy_r_w), 32'((k > 0) && (k % 3 == 0)));
            check_eq("w_valid", 32'(inst_valid_w), 32'((k > 0) && (k % 3 == 0)));
            if ((k > 0) && (k % 3 == 0)) begin
                check_eq("w_inst_pc", inst_pc_w, RA_W + 32'(4 * ((k - 1) / 3)));
                check_eq("w_inst", inst_w, (RA_W + 32'(4 * ((k - 1) / 3))) ^ KEY);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nanorv32_prefetch.md
# nanorv32_prefetch

Instruction prefetch stage of the nanorv32 core, sitting directly upstream of the pipeline flow controller. It owns the fetch PC and drives the code-memory request interface. Returned words are buffered with their addresses in a small FIFO and presented to decode. On a branch redirect it flushes and restarts, and it produces the registered `codeif_cpu_ready_r` handshake that the flow controller consumes.

## Interface

Parameters:
- `RESET_ADDR`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries; legal values are 2 and 4.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `branch_redirect`  in  1  redirect request; driven by the flow controller's `output_new_pc`.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `inst_ready`  in  1  decode accepts the head instruction this cycle.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid.
- `cpu_codeif_req`  out  1  code-memory read request.
- `cpu_codeif_addr`  out  32  code-memory read address, always the fetch PC.
- `codeif_cpu_ready`  in  1  memory completes the request this cycle; `codeif_cpu_rdata` is valid.
- `codeif_cpu_rdata`  in  32  read data.
- `codeif_cpu_ready_r`  out  1  registered transfer-complete flag, to the flow controller.

## Operation

State:
- `fetch_pc` (32 bits)
- `started_r` (1 bit)
- FIFO of `DEPTH` entries of {pc, word}, with `count` ranging 0..`DEPTH`
- `codeif_cpu_ready_r`

Request generation:
- `cpu_codeif_req = started_r && (count < DEPTH) && !branch_redirect`.
- `cpu_codeif_addr = fetch_pc`, unconditionally.

Transfer:
- A transfer is `cpu_codeif_req && codeif_cpu_ready`.
- On a transfer, push {`fetch_pc`, `codeif_cpu_rdata`} and set `fetch_pc <= fetch_pc + 4`.
- `fetch_pc` is 32-bit modulo: `32'hFFFF_FFFC` advances to `32'h0000_0000`.

Consumption:
- `inst_valid = (count != 0)`; `inst` and `inst_pc` are the FIFO head.
- Pop when `inst_valid && inst_ready`.
- Push and pop in the same cycle leave `count` unchanged.
- No push occurs when `count == DEPTH`, even if a pop happens in that cycle.

Redirect:
- `branch_redirect` has highest priority.
- Next cycle: `count = 0`, `fetch_pc = {branch_target[31:2], 2'b00}`.
- A pop or a `codeif_cpu_ready` in the redirect cycle is discarded.
- The request is suppressed in the redirect cycle, so no stale fetch completes.

Request rules:
- A request may be withdrawn without completion, on redirect or when the FIFO is full.
- The code memory treats `cpu_codeif_req` as sampled per cycle, with no outstanding-transaction state.
- The address is stable while `req` stays high without a redirect.

`codeif_cpu_ready_r`:
- Next value is `(cpu_codeif_req && codeif_cpu_ready)`.
- It is 0 in the cycle after a redirect.

Reset values (`rst_n` low at a rising edge):
- `fetch_pc = RESET_ADDR`
- `started_r = 0`
- `count = 0`
- all FIFO storage = 0
- `codeif_cpu_ready_r = 0`

Resulting outputs during reset:
- `inst_valid = 0`
- `inst = 0`
- `inst_pc = 0`
- `cpu_codeif_req = 0`
- `cpu_codeif_addr = RESET_ADDR`

Reset asserted mid-operation discards every in-flight request and all buffered words at that edge. `started_r` sets on the first edge with `rst_n` high.

## Timing

- First request: the cycle after the first clock edge with `rst_n` high.
- Fetch latency: a transfer in cycle N gives `inst_valid` in N+1 (FIFO previously empty) and `codeif_cpu_ready_r = 1` in N+1.
- Zero-wait memory with `inst_ready` held high: one instruction per cycle sustained.
- Redirect in cycle N:
  - N+1: `req = 1` at the target address, `inst_valid = 0`.
  - The target instruction is valid at N+2 at the earliest.
- Wait states: a memory holding `codeif_cpu_ready` low for k cycles delays the push by k cycles; address and `req` are held.

## Structure

- Shared parameters include: `NANORV32_RESET_ADDR` and `NANORV32_INST_WIDTH` (32), added next to the existing pipeline-state constants.
- One sub-module: `nanorv32_fetch_fifo`.
  - Synchronous FIFO, parameterised by `DEPTH` and width (64).
  - Ports: push, pop, flush, full, empty, head data.
  - Flush has priority over push and pop.
- Top level holds `fetch_pc`, `started_r`, request logic and `codeif_cpu_ready_r`.

## Test plan

- **Reset:** hold `rst_n` low 3 cycles, then release. Required:
  - `req = 0` throughout reset and in the first cycle after release.
  - `req = 1` at `addr = RESET_ADDR` in the next cycle.
  - All other outputs at their reset values.
- **Streaming:** zero-wait memory returns `rdata = addr ^ 32'hA5A5_A5A5`, `inst_ready = 1`. Required: `inst_pc` = 0, 4, 8, … one per cycle, and `inst` matches.
- **Backpressure, `DEPTH = 2`:** `inst_ready = 0`. Required:
  - `req` drops after two transfers; `count = 2`.
  - Raising `inst_ready` pops 0 then 4, and fetching resumes at 8 in the cycle after the first pop.
- **Redirect:** assert `branch_redirect` with `branch_target = 32'h0000_0103` while the FIFO is full and the memory is ready. Required:
  - Next cycle: `inst_valid = 0`, `req = 1`, `addr = 32'h0000_0100`, `codeif_cpu_ready_r = 0`.
  - No stale word is ever presented.
- **Wait states and wrap:** `RESET_ADDR = 32'hFFFF_FFF8` with 2 wait states per access. Required:
  - Addresses `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
  - Each address is held 3 cycles.
  - `codeif_cpu_ready_r` pulses once per word.
- **Reset mid-stream:** assert `rst_n = 0` for one cycle while `count = 1` and `req = 1`. Required:
  - Next cycle: `inst_valid = 0` and `req = 0`.
  - Fetching restarts at `RESET_ADDR`.
